laser_scan_ctrl: RTL and testbench

- Sequencer for the two-circle coverage search: counts incoming points, then alternately optimises target 1 and target 2 until both centres are stable.
- For each target it drives a shared coverage evaluator, which returns the covered-point count for a candidate centre.
- It drives the map mask unit, which clears and restores the other target's footprint.
- It tracks the best candidate per scan and reports C1/C2 with a DONE pulse.

---
 rtl/laser_scan_ctrl_if.sv | 42 ++++
 rtl/laser_scan_ctrl.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_laser_scan_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/laser_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// laser_scan_ctrl_if
//
// Purpose: groups the two request/response channels of the scan sequencer:
//   - coverage evaluator: request (ev_req_*, ev_pos) and in-order response
//     (ev_rsp_valid, ev_rsp_cnt)
//   - map mask unit: command (mk_cmd_*) and completion pulse (mk_done)
//
// Handshake rules (both command channels):
//   A transfer happens on a rising clock edge where valid and ready are both
//   high. While valid is high and ready is low, the sender holds valid and
//   every payload signal stable. Ready may be high without valid, and the
//   receiver may not make ready depend on the transfer completing.
//   ev_rsp_valid and mk_done have no back-pressure: each high cycle is one
//   response or one completion.
//
// Modports:
//   master - the sequencer (drives requests and commands)
//   slave  - evaluator / mask unit side
// ---------------------------------------------------------------------------
interface laser_scan_ctrl_if;
  logic       ev_req_valid;
  logic       ev_req_ready;
  logic [7:0] ev_pos;
  logic       ev_rsp_valid;
  logic [5:0] ev_rsp_cnt;
  logic       mk_cmd_valid;
  logic       mk_cmd_ready;
  logic       mk_cmd_op;
  logic [7:0] mk_cmd_center;
  logic       mk_done;

  modport master (
    output ev_req_valid, ev_pos, mk_cmd_valid, mk_cmd_op, mk_cmd_center,
    input  ev_req_ready, ev_rsp_valid, ev_rsp_cnt, mk_cmd_ready, mk_done
  );

  modport slave (
    input  ev_req_valid, ev_pos, mk_cmd_valid, mk_cmd_op, mk_cmd_center,
    output ev_req_ready, ev_rsp_valid, ev_rsp_cnt, mk_cmd_ready, mk_done
  );
endinterface

// File: rtl/laser_scan_ctrl.sv
// ---------------------------------------------------------------------------
// laser_scan_ctrl
//
// Purpose: sequencer for the two-circle coverage search. It counts NPTS
// incoming points, then alternately optimises target 1 and target 2. Each
// scan sweeps all 256 candidate centres through the shared coverage
// evaluator and keeps the best one; before every scan except the very first
// the other target's footprint is masked out of the map, and restored after.
// The search ends when two consecutive scans leave their target unchanged
// or after MAX_SCANS scans, and DONE pulses with C1/C2 final.
//
// Ports:
//   CLK          rising-edge clock
//   RST          asynchronous active-low reset
//   pt_valid     one point loaded into the map this cycle
//   bus          evaluator + mask unit channels (master side)
//   C1X..C2Y     result centres, held until the next frame's first point
//   DONE         one-cycle pulse, results final
//   busy         high in every state except IDLE
//   dbg_state_o  current FSM state (debug)
// ---------------------------------------------------------------------------
module laser_scan_ctrl #(
  parameter int NPTS      = 40,
  parameter int MAX_SCANS = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                pt_valid,
  laser_scan_ctrl_if.master   bus,
  output logic [3:0]          C1X,
  output logic [3:0]          C1Y,
  output logic [3:0]          C2X,
  output logic [3:0]          C2Y,
  output logic                DONE,
  output logic                busy,
  output logic [3:0]          dbg_state_o
);

  localparam int PW = $clog2(NPTS + 1);
  localparam int SW = $clog2(MAX_SCANS + 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_MASK,
    S_MASK_WAIT,
    S_SCAN,
    S_UNMASK,
    S_UNMASK_WAIT,
    S_UPDATE,
    S_FINISH
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   pt_cnt_q, pt_cnt_d;

  // Scan bookkeeping: next position to request, whether all 256 have been
  // requested, position of the oldest outstanding response, and the number
  // of requests still waiting for their response.
  logic [7:0]      req_pos_q, req_pos_d;
  logic            req_done_q, req_done_d;
  logic [7:0]      rsp_pos_q, rsp_pos_d;
  logic [8:0]      outst_q, outst_d;

  logic [5:0]      best_cnt_q, best_cnt_d;
  logic [7:0]      best_pos_q, best_pos_d;

  // Stored centres {y,x} and whether each target has completed a scan yet.
  logic [7:0]      c1_q, c1_d;
  logic [7:0]      c2_q, c2_d;
  logic            c1_vld_q, c1_vld_d;
  logic            c2_vld_q, c2_vld_d;

  logic            cur2_q, cur2_d;      // 0: target 1 is current, 1: target 2
  logic [1:0]      stable_q, stable_d;
  logic [SW-1:0]   scan_q, scan_d;
  logic [7:0]      mask_ctr_q, mask_ctr_d;

  logic            req_fire;
  logic            rsp_take;
  logic            upd_same;

  assign req_fire = bus.ev_req_valid & bus.ev_req_ready;

  // A response is only meaningful while a request is outstanding in SCAN;
  // anything else is a stray pulse and is dropped.
  assign rsp_take = (state_q == S_SCAN) && bus.ev_rsp_valid && (outst_q != 9'd0);

  // A target whose first scan has not completed has no valid centre, so its
  // first result always counts as a change.
  assign upd_same = cur2_q ? (c2_vld_q && (best_pos_q == c2_q))
                           : (c1_vld_q && (best_pos_q == c1_q));

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      pt_cnt_q   <= '0;
      req_pos_q  <= '0;
      req_done_q <= 1'b0;
      rsp_pos_q  <= '0;
      outst_q    <= '0;
      best_cnt_q <= '0;
      best_pos_q <= '0;
      c1_q       <= '0;
      c2_q       <= '0;
      c1_vld_q   <= 1'b0;
      c2_vld_q   <= 1'b0;
      cur2_q     <= 1'b0;
      stable_q   <= '0;
      scan_q     <= '0;
      mask_ctr_q <= '0;
    end else begin
      state_q    <= state_d;
      pt_cnt_q   <= pt_cnt_d;
      req_pos_q  <= req_pos_d;
      req_done_q <= req_done_d;
      rsp_pos_q  <= rsp_pos_d;
      outst_q    <= outst_d;
      best_cnt_q <= best_cnt_d;
      best_pos_q <= best_pos_d;
      c1_q       <= c1_d;
      c2_q       <= c2_d;
      c1_vld_q   <= c1_vld_d;
      c2_vld_q   <= c2_vld_d;
      cur2_q     <= cur2_d;
      stable_q   <= stable_d;
      scan_q     <= scan_d;
      mask_ctr_q <= mask_ctr_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    pt_cnt_d   = pt_cnt_q;
    // Scan counters drop back to zero whenever the FSM is outside SCAN, so
    // every scan starts from position 0 with nothing outstanding.
    req_pos_d  = '0;
    req_done_d = 1'b0;
    rsp_pos_d  = '0;
    outst_d    = '0;
    best_cnt_d = best_cnt_q;
    best_pos_d = best_pos_q;
    c1_d       = c1_q;
    c2_d       = c2_q;
    c1_vld_d   = c1_vld_q;
    c2_vld_d   = c2_vld_q;
    cur2_d     = cur2_q;
    stable_d   = stable_q;
    scan_d     = scan_q;
    mask_ctr_d = mask_ctr_q;

    case (state_q)
      S_IDLE: begin
        if (pt_valid) begin
          pt_cnt_d = PW'(1);
          c1_d     = '0;
          c2_d     = '0;
          c1_vld_d = 1'b0;
          c2_vld_d = 1'b0;
          cur2_d   = 1'b0;
          stable_d = '0;
          scan_d   = '0;
          state_d  = S_LOAD;
        end
      end

      S_LOAD: begin
        if (pt_valid) begin
          pt_cnt_d = pt_cnt_q + PW'(1);
          // First scan of target 1 runs unmasked: target 2 has no centre yet.
          if (pt_cnt_d == PW'(NPTS)) begin
            state_d = S_SCAN;
          end
        end
      end

      S_MASK: begin
        if (bus.mk_cmd_ready) begin
          state_d = S_MASK_WAIT;
        end
      end

      S_MASK_WAIT: begin
        if (bus.mk_done) begin
          state_d = S_SCAN;
        end
      end

      S_SCAN: begin
        req_pos_d  = req_pos_q;
        req_done_d = req_done_q;
        rsp_pos_d  = rsp_pos_q;
        if (req_fire) begin
          req_pos_d = req_pos_q + 8'd1;
          if (req_pos_q == 8'hFF) begin
            req_done_d = 1'b1;
          end
        end
        outst_d = outst_q + {8'd0, req_fire} - {8'd0, rsp_take};
        if (rsp_take) begin
          rsp_pos_d = rsp_pos_q + 8'd1;
          // '>=' lets a later position win a tie; position 0 seeds the scan.
          if ((rsp_pos_q == 8'd0) || (bus.ev_rsp_cnt >= best_cnt_q)) begin
            best_cnt_d = bus.ev_rsp_cnt;
            best_pos_d = rsp_pos_q;
          end
          if (rsp_pos_q == 8'hFF) begin
            state_d = (scan_q == '0) ? S_UPDATE : S_UNMASK;
          end
        end
      end

      S_UNMASK: begin
        if (bus.mk_cmd_ready) begin
          state_d = S_UNMASK_WAIT;
        end
      end

      S_UNMASK_WAIT: begin
        if (bus.mk_done) begin
          state_d = S_UPDATE;
        end
      end

      S_UPDATE: begin
        stable_d = upd_same ? (stable_q + 2'd1) : 2'd0;
        if (cur2_q) begin
          c2_d     = best_pos_q;
          c2_vld_d = 1'b1;
        end else begin
          c1_d     = best_pos_q;
          c1_vld_d = 1'b1;
        end
        scan_d = scan_q + SW'(1);
        cur2_d = ~cur2_q;
        // The target just written is the "other" one for the next scan, so
        // its new centre is the footprint to mask next.
        mask_ctr_d = best_pos_q;
        if ((stable_d == 2'd2) || (scan_d == SW'(MAX_SCANS))) begin
          state_d = S_FINISH;
        end else begin
          state_d = S_MASK;
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.ev_req_valid  = (state_q == S_SCAN) && !req_done_q;
  assign bus.ev_pos        = req_pos_q;
  assign bus.mk_cmd_valid  = (state_q == S_MASK) || (state_q == S_UNMASK);
  assign bus.mk_cmd_op     = (state_q == S_MASK);
  assign bus.mk_cmd_center = mask_ctr_q;

  assign C1X  = c1_q[3:0];
  assign C1Y  = c1_q[7:4];
  assign C2X  = c2_q[3:0];
  assign C2Y  = c2_q[7:4];
  assign DONE = (state_q == S_FINISH);
  assign busy = (state_q != S_IDLE);

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_laser_scan_ctrl.sv
`timescale 1ns/1ps
module tb_laser_scan_ctrl;
  localparam int NPTS      = 40;
  localparam int MAX_SCANS = 16;

  // -------------------------------------------------------------------------
  // Clock / reset / DUT
  // -------------------------------------------------------------------------
  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       pt_valid = 1'b0;
  logic [3:0] C1X, C1Y, C2X, C2Y;
  logic       DONE, busy;
  logic [3:0] dbg_state;

  laser_scan_ctrl_if bus();

  laser_scan_ctrl #(.NPTS(NPTS), .MAX_SCANS(MAX_SCANS)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .pt_valid   (pt_valid),
    .bus        (bus),
    .C1X        (C1X),
    .C1Y        (C1Y),
    .C2X        (C2X),
    .C2Y        (C2Y),
    .DONE       (DONE),
    .busy       (busy),
    .dbg_state_o(dbg_state)
  );

  always #5 CLK = ~CLK;

  // -------------------------------------------------------------------------
  // Shared stimulus configuration (written by the main sequence only)
  // -------------------------------------------------------------------------
  int tab [MAX_SCANS][256];   // evaluator answer per scan and position
  int rdy_mode = 0;           // 0 always ready, 1 toggling 1010, 2 random
  int lat_cfg  = 3;           // fixed response latency, 0 = random 1..4
  bit noise_en = 1'b0;

  // Scoreboard
  logic [8:0] exp_q[$];       // expected {op, centre} mask commands
  int n_tests = 0;
  int n_fail  = 0;

  // -------------------------------------------------------------------------
  // Evaluator + mask unit model and protocol monitor (written only here)
  // -------------------------------------------------------------------------
  int         cyc = 0;
  int         req_total = 0, rsp_total = 0;
  int         order_err = 0, hold_err = 0, seq_err = 0;
  int         frame_req = 0;
  logic [7:0] exp_pos = '0;
  int         pend_cnt[$];
  int         pend_due[$];
  int         last_due = 0;
  bit         mk_pending = 1'b0;
  int         mk_delay = 0;
  bit         hold_prev = 1'b0;
  logic [8:0] held = '0;
  bit         in_scan = 1'b0;
  bit         tog = 1'b0;
  logic [8:0] mk_log[$];

  initial begin
    bus.ev_req_ready = 1'b0;
    bus.ev_rsp_valid = 1'b0;
    bus.ev_rsp_cnt   = '0;
    bus.mk_cmd_ready = 1'b0;
    bus.mk_done      = 1'b0;
    forever begin
      @(negedge CLK);
      cyc++;
      // Drive phase: inputs seen by the DUT at the next rising edge.
      if (!RST) begin
        bus.ev_req_ready = 1'b0;
        bus.ev_rsp_valid = 1'b0;
        bus.mk_cmd_ready = 1'b0;
        bus.mk_done      = 1'b0;
      end else begin
        case (rdy_mode)
          0:       bus.ev_req_ready = 1'b1;
          1:       bus.ev_req_ready = tog;
          default: bus.ev_req_ready = ($urandom_range(0, 3) != 0);
        endcase
        tog = ~tog;
        if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
          bus.ev_rsp_valid = 1'b1;
          bus.ev_rsp_cnt   = 6'(pend_cnt.pop_front());
          void'(pend_due.pop_front());
        end else begin
          bus.ev_rsp_valid = 1'b0;
          bus.ev_rsp_cnt   = 6'($urandom_range(0, 63));
        end
        if (mk_pending) begin
          bus.mk_cmd_ready = 1'b0;
          if (mk_delay == 0) begin
            bus.mk_done = 1'b1;
            mk_pending  = 1'b0;
          end else begin
            bus.mk_done = 1'b0;
            mk_delay--;
          end
        end else begin
          bus.mk_cmd_ready = ($urandom_range(0, 2) != 0);
          // Stray completion pulses while the search is scanning.
          bus.mk_done = noise_en && in_scan && ($urandom_range(0, 15) == 0);
        end
      end
      // Observe phase: DUT outputs are settled, record upcoming transfers.
      #1;
      if (!RST) begin
        pend_cnt.delete();
        pend_due.delete();
        last_due   = 0;
        mk_pending = 1'b0;
        hold_prev  = 1'b0;
        in_scan    = 1'b0;
        exp_pos    = '0;
        frame_req  = 0;
      end else begin
        in_scan = bus.ev_req_valid;
        if (bus.ev_req_valid && bus.ev_req_ready) begin
          int sidx;
          int due;
          if (bus.ev_pos !== exp_pos) order_err++;
          exp_pos = exp_pos + 8'd1;
          sidx = frame_req / 256;
          if (sidx > MAX_SCANS - 1) sidx = MAX_SCANS - 1;
          pend_cnt.push_back(tab[sidx][bus.ev_pos]);
          due = cyc + ((lat_cfg == 0) ? int'($urandom_range(1, 4)) : lat_cfg);
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          pend_due.push_back(due);
          frame_req++;
          req_total++;
        end
        if (bus.ev_rsp_valid) rsp_total++;
        if (bus.ev_req_valid && (mk_pending || bus.mk_cmd_valid)) seq_err++;
        if (hold_prev && !(bus.mk_cmd_valid && ({bus.mk_cmd_op, bus.mk_cmd_center} === held)))
          hold_err++;
        hold_prev = bus.mk_cmd_valid && !bus.mk_cmd_ready;
        held      = {bus.mk_cmd_op, bus.mk_cmd_center};
        if (bus.mk_cmd_valid && bus.mk_cmd_ready) begin
          mk_log.push_back({bus.mk_cmd_op, bus.mk_cmd_center});
          mk_pending = 1'b1;
          mk_delay   = $urandom_range(0, 3);
        end
        if (!busy) frame_req = 0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Checking helpers
  // -------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_valid"}, 32'(bus.ev_req_valid), 0);
    check({tag, "_ev_pos"},    32'(bus.ev_pos), 0);
    check({tag, "_mk_valid"},  32'(bus.mk_cmd_valid), 0);
    check({tag, "_mk_op"},     32'(bus.mk_cmd_op), 0);
    check({tag, "_mk_center"}, 32'(bus.mk_cmd_center), 0);
    check({tag, "_c"},         32'({C1X, C1Y, C2X, C2Y}), 0);
    check({tag, "_done"},      32'(DONE), 0);
    check({tag, "_busy"},      32'(busy), 0);
  endtask

  // -------------------------------------------------------------------------
  // Reference model: evaluator tables and the search outcome
  // -------------------------------------------------------------------------
  task automatic build_tables(input int mode);
    int a, b;
    a = int'($urandom_range(0, 255));
    b = (a + int'($urandom_range(1, 255))) % 256;
    for (int s = 0; s < MAX_SCANS; s++) begin
      for (int p = 0; p < 256; p++) begin
        case (mode)
          0:       tab[s][p] = (p == 'h37) ? 5 : 0;
          1:       tab[s][p] = (p == 'h12 || p == 'h80) ? 9 : 0;
          2:       tab[s][p] = (p == 'h12) ? 10 : ((p == 'h80) ? 9 : 0);
          3:       tab[s][p] = (p == (((s / 2) % 2 == 1) ? b : a)) ? 40 : int'($urandom_range(0, 20));
          default: tab[s][p] = int'($urandom_range(0, 63));
        endcase
      end
    end
  endtask

  // Best centre of a scan: highest count, highest position among equals.
  function automatic logic [7:0] best_of(input int s);
    int mx;
    logic [7:0] r;
    mx = -1;
    r  = '0;
    for (int p = 0; p < 256; p++) if (tab[s][p] > mx) mx = tab[s][p];
    for (int p = 0; p < 256; p++) if (tab[s][p] == mx) r = 8'(p);
    return r;
  endfunction

  task automatic build_model(output int n_scans, output logic [7:0] e1, output logic [7:0] e2);
    logic [7:0] c[2];
    bit         v[2];
    logic [7:0] best;
    int         stable;
    int         cur;
    exp_q.delete();
    c[0] = '0; c[1] = '0; v[0] = 0; v[1] = 0;
    stable = 0; cur = 0; n_scans = 0;
    forever begin
      if (n_scans > 0) exp_q.push_back({1'b1, c[1 - cur]});
      best = best_of(n_scans);
      if (n_scans > 0) exp_q.push_back({1'b0, c[1 - cur]});
      stable = (v[cur] && best == c[cur]) ? stable + 1 : 0;
      c[cur] = best;
      v[cur] = 1;
      n_scans++;
      cur = 1 - cur;
      if (stable >= 2 || n_scans == MAX_SCANS) break;
    end
    e1 = c[0];
    e2 = c[1];
  endtask

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic send_points();
    for (int i = 0; i < NPTS; i++) begin
      @(negedge CLK);
      pt_valid = 1'b1;
      @(negedge CLK);
      pt_valid = 1'b0;
      if (i == 0) begin
        #2;
        check("first_pt_busy", 32'(busy), 1);
        check("first_pt_c_clear", 32'({C1X, C1Y, C2X, C2Y}), 0);
      end
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end
  endtask

  task automatic run_frame(input string tag, input int mode, input int rm, input int lat);
    int         n_scans;
    logic [7:0] e1, e2;
    int         b_req, b_rsp, b_ord, b_hold, b_seq, b_mk;
    int         got;
    int         mism;
    build_tables(mode);
    build_model(n_scans, e1, e2);
    rdy_mode = rm;
    lat_cfg  = lat;
    b_req = req_total; b_rsp = rsp_total; b_ord = order_err;
    b_hold = hold_err; b_seq = seq_err;  b_mk = mk_log.size();
    send_points();
    noise_en = 1'b1;
    got = 0;
    for (int k = 0; k < 30000; k++) begin
      @(negedge CLK);
      pt_valid = noise_en && in_scan && ($urandom_range(0, 3) == 0);
      #2;
      if (DONE) begin
        got = 1;
        break;
      end
    end
    pt_valid = 1'b0;
    noise_en = 1'b0;
    check({tag, "_done_seen"}, 32'(got), 1);
    check({tag, "_busy_at_done"}, 32'(busy), 1);
    check({tag, "_c1x"}, 32'(C1X), 32'(e1[3:0]));
    check({tag, "_c1y"}, 32'(C1Y), 32'(e1[7:4]));
    check({tag, "_c2x"}, 32'(C2X), 32'(e2[3:0]));
    check({tag, "_c2y"}, 32'(C2Y), 32'(e2[7:4]));
    check({tag, "_requests"}, 32'(req_total - b_req), 32'(256 * n_scans));
    check({tag, "_responses"}, 32'(rsp_total - b_rsp), 32'(256 * n_scans));
    check({tag, "_req_order_errs"}, 32'(order_err - b_ord), 0);
    check({tag, "_mk_hold_errs"}, 32'(hold_err - b_hold), 0);
    check({tag, "_req_during_mask"}, 32'(seq_err - b_seq), 0);
    check({tag, "_mk_count"}, 32'(mk_log.size() - b_mk), 32'(exp_q.size()));
    mism = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (b_mk + i >= mk_log.size()) mism++;
      else if (mk_log[b_mk + i] !== exp_q[i]) mism++;
    end
    check({tag, "_mk_seq"}, 32'(mism), 0);
    @(negedge CLK);
    #2;
    check({tag, "_done_one_cycle"}, 32'(DONE), 0);
    check({tag, "_idle_after"}, 32'(busy), 0);
    repeat (5) @(negedge CLK);
    #2;
    check({tag, "_c_hold"}, 32'({C1X, C1Y, C2X, C2Y}),
          32'({e1[3:0], e1[7:4], e2[3:0], e2[7:4]}));
  endtask

  // -------------------------------------------------------------------------
  // Directed sequence
  // -------------------------------------------------------------------------
  initial begin
    int base;
    int found;
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    check_idle_outputs("reset");
    @(negedge CLK);
    RST = 1'b1;

    run_frame("peak37", 0, 0, 3);
    run_frame("tie_9_9", 1, 1, 3);
    run_frame("tie_10_9", 2, 2, 0);
    run_frame("alternate", 3, 1, 3);
    run_frame("random_a", 4, 2, 0);
    run_frame("random_b", 4, 0, 0);

    // Reset in the middle of a scan, with position 100 presented.
    build_tables(0);
    rdy_mode = 0;
    lat_cfg  = 3;
    base = req_total;
    send_points();
    found = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge CLK);
      #2;
      if (req_total - base == 100) begin
        found = 1;
        break;
      end
    end
    check("reach_pos100", 32'(found), 1);
    @(negedge CLK);
    check("pos_before_reset", 32'(bus.ev_pos), 100);
    RST = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    repeat (3) @(negedge CLK);
    RST = 1'b1;

    run_frame("after_reset", 0, 2, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
